// File: rtl/fft_bitrev_reorder_if.sv
// Streaming bus for the bit-reversal reorder buffer.
// Bit-reversed samples go in, natural-order samples come out.
interface fft_bitrev_reorder_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  in_val;
  logic [DATA_WIDTH-1:0] in_re;
  logic [DATA_WIDTH-1:0] in_im;
  logic                  out_ready;
  logic                  out_val;
  logic [DATA_WIDTH-1:0] out_re;
  logic [DATA_WIDTH-1:0] out_im;
  logic                  out_last;
  logic                  overflow;

  // Producer/consumer side (testbench or surrounding pipeline)
  modport master (
    output in_val, in_re, in_im, out_ready,
    input  out_val, out_re, out_im, out_last, overflow
  );

  // Reorder buffer side
  modport slave (
    input  in_val, in_re, in_im, out_ready,
    output out_val, out_re, out_im, out_last, overflow
  );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer converting a bit-reversed FFT output stream
// into natural frame order. Two banks of N_POINTS complex entries are
// written at bitrev(wcnt) and drained at ascending addresses through a
// single registered output stage with a valid/ready handshake.
module fft_bitrev_reorder #(
  parameter int DATA_WIDTH = 16,
  parameter int N_POINTS   = 16
) (
  input logic                 clk,
  input logic                 rst,
  fft_bitrev_reorder_if.slave bus
);
  localparam int AW = $clog2(N_POINTS);
  localparam logic [AW-1:0] LAST_IDX   = AW'(N_POINTS - 1);
  localparam logic [AW-1:0] PENULT_IDX = AW'(N_POINTS - 2);
  localparam logic [AW-1:0] ONE        = AW'(1);

  typedef enum logic [1:0] {BANK_FREE, BANK_FILLING, BANK_FULL} bank_state_t;
  typedef enum logic {RD_IDLE, RD_DRAIN} rd_state_t;

  bank_state_t r_bankState [2];
  logic        r_wrBank;
  logic        r_rdBank;
  logic [AW-1:0] r_wcnt;
  logic [AW-1:0] r_rcnt;
  logic        r_dropping;
  logic        r_overflow;
  rd_state_t   r_rdState;
  logic        r_outVal;
  logic        r_outLast;
  logic [DATA_WIDTH-1:0] r_outRe;
  logic [DATA_WIDTH-1:0] r_outIm;
  logic [2*DATA_WIDTH-1:0] r_mem [2*N_POINTS];

  logic [AW-1:0] w_wrAddr;
  logic          w_transfer;
  logic          w_lastXfer;
  logic          w_nextFull;
  logic          w_rdReleased;
  logic          w_startOk;
  logic          w_accept;
  logic          w_frameStart;
  logic          w_frameDone;
  logic          w_load;
  logic          w_loadBank;
  logic [AW-1:0] w_loadAddr;
  logic [2*DATA_WIDTH-1:0] w_rdData;

  // Write address is the bit-reversed write counter
  always_comb begin
    w_wrAddr = '0;
    for (int i = 0; i < AW; i++) begin
      w_wrAddr[i] = r_wcnt[AW-1-i];
    end
  end

  assign w_transfer = r_outVal && bus.out_ready;
  assign w_lastXfer = w_transfer && (r_rcnt == LAST_IDX);
  assign w_nextFull = (r_bankState[~r_rdBank] == BANK_FULL);

  // The bank being drained may be refilled once its final entry has been
  // fetched into the output register (or is being fetched this cycle):
  // every RAM slot has been read, so a new frame cannot clobber pending data.
  // Without this, a gapless input stream would hit a still-FULL bank one
  // cycle before its last sample leaves the output register.
  assign w_rdReleased = (r_rdState == RD_DRAIN) && (r_rdBank == r_wrBank) &&
                        (r_bankState[r_wrBank] == BANK_FULL) &&
                        ((r_outVal && r_outLast) ||
                         (w_transfer && (r_rcnt == PENULT_IDX)));

  assign w_startOk    = (r_bankState[r_wrBank] == BANK_FREE) || w_rdReleased;
  assign w_frameStart = bus.in_val && (r_wcnt == '0);
  assign w_accept     = bus.in_val && ((r_wcnt == '0) ? w_startOk : !r_dropping);
  assign w_frameDone  = w_accept && (r_wcnt == LAST_IDX);

  // Select which RAM entry, if any, is loaded into the output register
  always_comb begin
    w_load     = 1'b0;
    w_loadBank = r_rdBank;
    w_loadAddr = r_rcnt;
    if (r_rdState == RD_DRAIN) begin
      if (!r_outVal) begin
        w_load = 1'b1;
      end else if (w_transfer) begin
        if (r_rcnt != LAST_IDX) begin
          w_load     = 1'b1;
          w_loadAddr = r_rcnt + ONE;
        end else if (w_nextFull) begin
          w_load     = 1'b1;
          w_loadBank = ~r_rdBank;
          w_loadAddr = '0;
        end
      end
    end
  end

  assign w_rdData = r_mem[{w_loadBank, w_loadAddr}];

  // Sample storage; contents are not cleared by reset
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[{r_wrBank, w_wrAddr}] <= {bus.in_re, bus.in_im};
    end
  end

  // Write counter, frame-drop tracking and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wcnt     <= '0;
      r_dropping <= 1'b0;
      r_overflow <= 1'b0;
    end else if (bus.in_val) begin
      r_wcnt <= r_wcnt + ONE;
      if (r_wcnt == '0) begin
        r_dropping <= !w_startOk;
        if (!w_startOk) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  // Bank ownership; a write completion and a drain completion may coincide
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bankState[0] <= BANK_FREE;
      r_bankState[1] <= BANK_FREE;
      r_wrBank       <= 1'b0;
    end else begin
      if (w_lastXfer && (r_bankState[r_rdBank] == BANK_FULL)) begin
        r_bankState[r_rdBank] <= BANK_FREE;
      end
      if (w_frameStart && w_startOk) begin
        r_bankState[r_wrBank] <= BANK_FILLING;
      end
      if (w_frameDone) begin
        r_bankState[r_wrBank] <= BANK_FULL;
        r_wrBank              <= ~r_wrBank;
      end
    end
  end

  // Read FSM with registered output stage held stable while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdState <= RD_IDLE;
      r_rcnt    <= '0;
      r_rdBank  <= 1'b0;
      r_outVal  <= 1'b0;
      r_outLast <= 1'b0;
      r_outRe   <= '0;
      r_outIm   <= '0;
    end else begin
      case (r_rdState)
        RD_IDLE: begin
          if (r_bankState[r_rdBank] == BANK_FULL) begin
            r_rdState <= RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          if (w_lastXfer) begin
            r_rcnt   <= '0;
            r_rdBank <= ~r_rdBank;
            if (!w_nextFull) begin
              r_rdState <= RD_IDLE;
              r_outVal  <= 1'b0;
              r_outLast <= 1'b0;
            end
          end else if (w_transfer) begin
            r_rcnt <= r_rcnt + ONE;
          end
          if (w_load) begin
            r_outVal  <= 1'b1;
            r_outRe   <= w_rdData[2*DATA_WIDTH-1:DATA_WIDTH];
            r_outIm   <= w_rdData[DATA_WIDTH-1:0];
            r_outLast <= (w_loadAddr == LAST_IDX);
          end
        end
        default: r_rdState <= RD_IDLE;
      endcase
    end
  end

  assign bus.out_val  = r_outVal;
  assign bus.out_re   = r_outRe;
  assign bus.out_im   = r_outIm;
  assign bus.out_last = r_outLast;
  assign bus.overflow = r_overflow;
endmodule
